// File: rtl/dmem_ctrl.sv
// dmem_ctrl: data-memory controller between the memory-access stage and a 32-bit synchronous SRAM.
// Ports:
//   clk, rstn         clock, synchronous active-low reset
//   req, wenable      access request from the memory-access stage, 1=store 0=load
//   wide              1=WIDE_W-bit multi-beat access, 0=scalar
//   addr              byte address
//   rcntl, wcntl      scalar load / store width controls
//   wdata, wdata_512  scalar and wide store data
//   dmemrdata(_512)   registered scalar and wide load results
//   stall             freeze the pipeline while a multi-cycle access is in flight
//   misalign          one-cycle pulse after a misaligned request
//   mem_*             single-port SRAM interface, read data valid one cycle after a read
module dmem_ctrl #(
    parameter int ADDR_W = 14,
    parameter int WIDE_W = 1048
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              req,
    input  logic              wenable,
    input  logic              wide,
    input  logic [31:0]       addr,
    input  logic [2:0]        rcntl,
    input  logic [2:0]        wcntl,
    input  logic [31:0]       wdata,
    input  logic [WIDE_W-1:0] wdata_512,
    output logic [31:0]       dmemrdata,
    output logic [WIDE_W-1:0] dmemrdata_512,
    output logic              stall,
    output logic              misalign,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_wstrb,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);
    localparam int BEATS = (WIDE_W + 31) / 32;
    localparam int BW = $clog2(BEATS + 1);
    localparam int PW = 32 * BEATS;
    localparam int LW = WIDE_W - 32 * (BEATS - 1);
    localparam logic [3:0] LAST_STRB = (LW == 32) ? 4'hF : 4'((1 << (LW / 8)) - 1);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] SRD  = 3'd1;
    localparam logic [2:0] WRD  = 3'd2;
    localparam logic [2:0] WWR  = 3'd3;
    localparam logic [2:0] DONE = 3'd4;

    logic [2:0]              state;
    logic [BW-1:0]           beat;
    logic [ADDR_W-1:0]       base;
    logic [1:0]              lane;
    logic [2:0]              rc;
    logic [32*(BEATS-1)-1:0] wbuf;

    logic [ADDR_W-1:0] waddr;
    logic              sz_b, sz_h, mis, go;
    logic [3:0]        sstrb, wstrb_w;
    logic [31:0]       sdata, wbeat, ld;
    logic [PW-1:0]     wpad;
    logic [BW-1:0]     cur;
    logic [7:0]        ld_b;
    logic [15:0]       ld_h;
    logic              unused_ok;

    assign unused_ok = ^addr[31:ADDR_W+2];
    assign waddr = addr[ADDR_W+1:2];

    // Unlisted control encodings fall through to full-word width.
    assign sz_b = wenable ? (wcntl == 3'b000) : (rcntl[1:0] == 2'b00);
    assign sz_h = wenable ? (wcntl == 3'b001) : (rcntl[1:0] == 2'b01);
    assign mis  = wide ? (addr[1:0] != 2'b00) : sz_h ? addr[0] : (!sz_b && addr[1:0] != 2'b00);
    assign go   = req && !mis;

    assign sstrb = sz_b ? (4'b0001 << addr[1:0]) : sz_h ? (addr[1] ? 4'b1100 : 4'b0011) : 4'hF;
    assign sdata = sz_b ? {4{wdata[7:0]}} : sz_h ? {2{wdata[15:0]}} : wdata;

    // The request cycle issues beat 0; later store beats come from the counter.
    assign wpad    = PW'(wdata_512);
    assign cur     = (state == WWR) ? beat : '0;
    assign wbeat   = wpad[32*cur +: 32];
    assign wstrb_w = (cur == BW'(BEATS - 1)) ? LAST_STRB : 4'hF;

    assign ld_b = mem_rdata[8*lane +: 8];
    assign ld_h = lane[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    assign ld   = (rc[1:0] == 2'b00) ? {{24{!rc[2] && ld_b[7]}}, ld_b} :
                  (rc[1:0] == 2'b01) ? {{16{!rc[2] && ld_h[15]}}, ld_h} : mem_rdata;

    always_comb begin
        stall     = 1'b0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wstrb = '0;
        mem_wdata = '0;
        if (rstn && state == IDLE && go) begin
            stall     = !(wenable && !wide);
            mem_en    = 1'b1;
            mem_we    = wenable;
            mem_addr  = waddr;
            mem_wstrb = wenable ? (wide ? wstrb_w : sstrb) : 4'h0;
            mem_wdata = wenable ? (wide ? wbeat : sdata) : 32'h0;
        end else if (rstn && (state == WWR || state == WRD)) begin
            // In WRD the extra beat==BEATS cycle only collects the last read.
            stall     = beat != BW'(BEATS);
            mem_en    = beat != BW'(BEATS);
            mem_we    = state == WWR;
            mem_addr  = base + ADDR_W'(beat);
            mem_wstrb = (state == WWR) ? wstrb_w : 4'h0;
            mem_wdata = (state == WWR) ? wbeat : 32'h0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state         <= IDLE;
            beat          <= '0;
            base          <= '0;
            lane          <= '0;
            rc            <= '0;
            wbuf          <= '0;
            dmemrdata     <= '0;
            dmemrdata_512 <= '0;
            misalign      <= 1'b0;
        end else begin
            misalign <= (state == IDLE) && req && mis;
            case (state)
                IDLE: if (go) begin
                    base  <= waddr;
                    lane  <= addr[1:0];
                    rc    <= rcntl;
                    beat  <= BW'(1);
                    state <= wide ? (wenable ? WWR : WRD) : (wenable ? IDLE : SRD);
                end
                SRD: begin
                    dmemrdata <= ld;
                    state     <= DONE;
                end
                WWR: begin
                    beat <= beat + 1'b1;
                    if (beat == BW'(BEATS - 1)) state <= DONE;
                end
                WRD: begin
                    if (beat == BW'(BEATS)) begin
                        dmemrdata_512 <= {mem_rdata[LW-1:0], wbuf};
                        state         <= DONE;
                    end else begin
                        wbuf[32*(beat-1'b1) +: 32] <= mem_rdata;
                        beat                       <= beat + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
- Data-memory controller directly downstream of the memory-access stage.
- Consumes that stage's address, write-enable, load/store width controls, scalar store data and 1048-bit NPU store data.
- Drives a single-port, 32-bit, word-addressed synchronous SRAM with 1-cycle read latency.
- Returns width-converted scalar load data and reassembled 1048-bit wide load data, and raises stall while a multi-cycle access is in flight.

Parameters:
ADDR_W, 14, SRAM word-address width (depth 2^ADDR_W words)
WIDE_W, 1048, wide-access data width; BEATS = ceil(WIDE_W/32) = 33

Ports:
clk  input  1  clock
rstn  input  1  synchronous active-low reset
req  input  1  memory access present in memory-access stage this cycle
wenable  input  1  1=store, 0=load
wide  input  1  1=1048-bit access (flag512), 0=scalar
addr  input  32  byte address
rcntl  input  3  load width: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu
wcntl  input  3  store width: 000 sb, 001 sh, 010 sw
wdata  input  32  scalar store data
wdata_512  input  1048  wide store data
dmemrdata  output  32  registered scalar load result
dmemrdata_512  output  1048  registered wide load result
stall  output  1  freeze pipeline registers
misalign  output  1  1-cycle pulse on misaligned access
mem_en  output  1  SRAM enable
mem_we  output  1  SRAM write
mem_addr  output  ADDR_W  SRAM word address
mem_wstrb  output  4  SRAM byte strobes
mem_wdata  output  32  SRAM write data
mem_rdata  input  32  SRAM read data, valid the cycle after mem_en with mem_we=0

Behaviour:
- Reset (rstn=0 at a clk edge): state IDLE, beat counter 0, dmemrdata=0, dmemrdata_512=0, misalign=0.
- During any cycle with rstn=0, stall, mem_en, mem_we, mem_addr, mem_wstrb and mem_wdata are forced to 0.
- Reset mid-access aborts the access: no further SRAM ops, partial wide buffer cleared.
- State machine states: IDLE, SRD, WRD, WWR, DONE.
- Word address = addr[ADDR_W+1:2]. Wide beat address = base + beat, modulo 2^ADDR_W (wraps).
- Misalignment rules:
  - Scalar half access with addr[0]=1, or word access with addr[1:0]!=0, is misaligned.
  - Wide access with addr[1:0]!=0 is misaligned.
  - Misaligned access: misalign=1 for one cycle, no SRAM op, no stall, outputs unchanged, stay IDLE.
- In IDLE, mem signals are driven combinationally from the inputs in the request cycle T.
- Scalar store:
  - Single cycle at T: mem_we=1, stall=0, stay IDLE.
  - sb: wstrb = 1<<addr[1:0], wdata = byte replicated x4.
  - sh: wstrb = 0011 or 1100 by addr[1], wdata = half replicated x2.
  - sw: wstrb = 1111.
- Scalar load:
  - T: read issued, stall=1, go to SRD.
  - T+1: byte/half lane selected by addr[1:0] (captured at T), sign- or zero-extended per rcntl, registered into dmemrdata; state DONE, stall=0.
- Wide store (WWR):
  - Beats 0..32 issued at T..T+32, beat k = wdata_512[32k+31:32k].
  - Last beat carries bits 1047:1024 with wstrb=0111, upper byte 0. All other beats wstrb=1111.
  - stall=1 for T..T+32; DONE at T+33 with stall=0.
- Wide load (WRD):
  - Reads issued T..T+32; beat k data arriving at T+k+1 is written into the buffer.
  - Last beat uses mem_rdata[23:0] only.
  - stall=1 for T..T+32. At T+33: dmemrdata_512 updated with the full buffer, state DONE, stall=0.
- DONE: ignores req (the same instruction is still presented), unconditionally returns to IDLE next cycle, mem_en=0.
- dmemrdata and dmemrdata_512 hold their value until the next load of the same kind completes. Stores never alter them.
- rcntl/wcntl encodings not listed above: treated as lw/sw.

Test Plan:
- Reset: rstn=0 for 2 cycles mid-traffic -> all outputs 0. First req after rstn=1 is accepted in IDLE.
- Scalar bytes/halves:
  - sw 0x8000_00FF to 0x10; then lb 0x10 -> dmemrdata=0xFFFF_FFFF; lbu 0x10 -> 0x0000_00FF.
  - lh 0x12 -> 0xFFFF_8000. Each load has stall high exactly 1 cycle.
- Byte store: sb 0xAB to 0x22 -> mem_wstrb=0100, mem_wdata=0xABAB_ABAB, stall never asserted; following lw 0x20 shows byte 2 = 0xAB.
- Misalignment: lh 0x13 -> misalign 1-cycle pulse, mem_en=0, stall=0, dmemrdata unchanged. sw 0x21 -> same.
- Wide round trip:
  - Wide store of pattern beat k = k*0x0101_0101 at 0x100 -> 33 writes at word addrs 0x40..0x60, last wstrb=0111, stall high 33 cycles.
  - Wide load from 0x100 -> dmemrdata_512 matches pattern with bits 1047:1024 = 0x202020, stall high 33 cycles.
- Wrap and reset abort:
  - Wide load at byte addr (2^ADDR_W-2)*4 -> beats 2..32 read word addrs 0..30.
  - Reset asserted at beat 10 of a wide load -> stall=0 next cycle, dmemrdata_512=0.
